cordic_result_collector: RTL and testbench
==========================================

CORDIC_RESULT_COLLECTOR -- requirements
Module: cordic_result_collector

Interface
REQ-001 Parameter WIDTH, 16, bit width of each CORDIC datapath word (x, y, z).
REQ-002 Parameter NUM_ITER, 16, number of CORDIC iterations per conversion (legal range 2..16).
REQ-003 Parameter ITER_W, 4, width of the iteration index, ceil(log2(NUM_ITER)).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high (ports clk and rst).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 start  input  1  request a new conversion; sampled on rising clk.
REQ-008 x_in, y_in, z_in  input  WIDTH each  live outputs of the iterative CORDIC stage.
REQ-009 first_iter  output  1  high during the first RUN cycle; drives the datapath input mux to select the fresh operand rather than feedback.
REQ-010 iter  output  ITER_W  current iteration index; drives the shift amount and the angle-ROM address.
REQ-011 busy  output  1  high in RUN and HOLD.
REQ-012 x_out, y_out, z_out  output  WIDTH each  registered result words.
REQ-013 out_valid  output  1  result words are valid.
REQ-014 out_ready  input  1  downstream accepts the result when high together with out_valid.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and HOLD.
REQ-016 In IDLE, start=1 at an edge SHALL move the FSM to RUN with iter=0. With start=0 the FSM SHALL stay in IDLE.
REQ-017 In RUN, iter SHALL increment by 1 on every edge.
REQ-018 first_iter SHALL equal (state==RUN && iter==0) and SHALL be decoded from registered state only.
REQ-019 At the edge where state==RUN and iter==NUM_ITER-1, the block SHALL capture x_in/y_in/z_in into x_out/y_out/z_out, set out_valid=1, reset iter to 0 and enter HOLD.
REQ-020 Latency: if start is accepted at edge k, out_valid SHALL first be high after edge k+NUM_ITER.
REQ-021 In HOLD, x_out/y_out/z_out SHALL be stable and out_valid SHALL stay 1 until out_ready=1 at an edge.
REQ-022 At a HOLD edge with out_ready=1 and start=0, the block SHALL clear out_valid and enter IDLE.
REQ-023 At a HOLD edge with out_ready=1 and start=1, the block SHALL clear out_valid and enter RUN with iter=0 (back-to-back conversion, no IDLE bubble).
REQ-024 start SHALL be ignored in RUN, and in HOLD while out_ready=0. No request is queued.
REQ-025 out_ready SHALL be ignored while out_valid=0.
REQ-026 iter SHALL never exceed NUM_ITER-1 and SHALL hold 0 in IDLE and HOLD.
REQ-027 The result registers SHALL update only at the capture edge defined in REQ-019 and SHALL otherwise retain their values, including across IDLE.
REQ-028 busy SHALL be (state!=IDLE).

Reset
REQ-029 Asserting rst SHALL immediately set the following, independent of clk: state=IDLE, iter=0, first_iter=0, busy=0, out_valid=0, x_out=y_out=z_out=0.
REQ-030 A reset asserted mid-RUN or mid-HOLD SHALL abort the conversion with no result delivered.
REQ-031 After rst is released, the first start SHALL be honoured at the first rising edge at which it is sampled high.

Verification
REQ-032 Basic conversion: rst=1 for 10 ns, then release and pulse start=1 for one cycle, with x_in=16'h1234, y_in=16'h0567, z_in=16'h0ABC held, out_ready=1 -> first_iter high for exactly 1 cycle; iter steps 0..15; out_valid high after exactly 16 edges; x_out=16'h1234; busy drops after the handshake edge.
REQ-033 Backpressure: out_ready=0 for 5 cycles after out_valid rises, while x_in changes every cycle -> out_valid and x_out stay constant; the handshake occurs on the first edge with out_ready=1.
REQ-034 Back-to-back: start=1 and out_ready=1 held continuously -> out_valid is high for exactly 1 cycle of every 17; first_iter follows each handshake with no IDLE cycle.
REQ-035 Ignored start: pulse start at iter=7 during RUN -> there is no restart, and only one result is produced.
REQ-036 Reset mid-operation: assert rst asynchronously (between edges) at iter=9 -> all outputs are 0 within the same time step, and the next start gives normal 16-cycle latency.
REQ-037 Idle: start=0 for 20 cycles after reset -> busy=0, iter=0, out_valid=0 throughout.

Source files
------------

// File: rtl/cordic_result_collector.sv
// Result collector and sequencer for an iterative CORDIC stage: steps the iteration
// index, captures the final x/y/z words and holds them under a valid/ready handshake.
module cordic_result_collector #(
   parameter int WIDTH    = 16,
   parameter int NUM_ITER = 16,
   parameter int ITER_W   = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [WIDTH-1:0]  x_in,
   input  logic [WIDTH-1:0]  y_in,
   input  logic [WIDTH-1:0]  z_in,
   output logic              first_iter,
   output logic [ITER_W-1:0] iter,
   output logic              busy,
   output logic [WIDTH-1:0]  x_out,
   output logic [WIDTH-1:0]  y_out,
   output logic [WIDTH-1:0]  z_out,
   output logic              out_valid,
   input  logic              out_ready
);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   localparam logic [ITER_W-1:0] LAST_ITER = ITER_W'(NUM_ITER - 1);

   state_t            state_q, state_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic              valid_q, valid_d;
   logic [WIDTH-1:0]  x_q, x_d;
   logic [WIDTH-1:0]  y_q, y_d;
   logic [WIDTH-1:0]  z_q, z_d;

   always_comb begin
      state_d = state_q;
      iter_d  = iter_q;
      valid_d = valid_q;
      x_d     = x_q;
      y_d     = y_q;
      z_d     = z_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               iter_d  = '0;
            end
         end
         RUN: begin
            if (iter_q == LAST_ITER) begin
               x_d     = x_in;
               y_d     = y_in;
               z_d     = z_in;
               valid_d = 1'b1;
               iter_d  = '0;
               state_d = HOLD;
            end else begin
               iter_d = iter_q + ITER_W'(1);
            end
         end
         HOLD: begin
            // A handshake with start pending re-enters RUN directly, skipping IDLE.
            if (out_ready) begin
               valid_d = 1'b0;
               iter_d  = '0;
               state_d = start ? RUN : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            iter_d  = '0;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         iter_q  <= '0;
         valid_q <= 1'b0;
         x_q     <= '0;
         y_q     <= '0;
         z_q     <= '0;
      end else begin
         state_q <= state_d;
         iter_q  <= iter_d;
         valid_q <= valid_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
      end
   end

   assign first_iter = (state_q == RUN) && (iter_q == '0);
   assign busy       = (state_q != IDLE);
   assign iter       = iter_q;
   assign out_valid  = valid_q;
   assign x_out      = x_q;
   assign y_out      = y_q;
   assign z_out      = z_q;

endmodule

// File: tb/tb_cordic_result_collector.sv
// Directed/random bench for cordic_result_collector against a transaction-level model.
module tb_cordic_result_collector;

   localparam int WIDTH    = 16;
   localparam int NUM_ITER = 16;
   localparam int ITER_W   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [WIDTH-1:0]  x_in, y_in, z_in;
   logic              first_iter;
   logic [ITER_W-1:0] iter;
   logic              busy;
   logic [WIDTH-1:0]  x_out, y_out, z_out;
   logic              out_valid;
   logic              out_ready;

   int n_chk  = 0;
   int n_fail = 0;
   bit rnd    = 1'b0;

   // Model: a conversion in flight counts elapsed cycles; a finished one holds a result.
   bit          m_busy  = 1'b0;
   bit          m_valid = 1'b0;
   int          m_k     = 0;
   logic [15:0] m_x = '0, m_y = '0, m_z = '0;

   cordic_result_collector #(
      .WIDTH(WIDTH),
      .NUM_ITER(NUM_ITER),
      .ITER_W(ITER_W)
   ) dut (
      .clk(clk), .rst(rst), .start(start),
      .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .first_iter(first_iter), .iter(iter), .busy(busy),
      .x_out(x_out), .y_out(y_out), .z_out(z_out),
      .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_valid = 0; m_k = 0; m_x = '0; m_y = '0; m_z = '0;
   endtask

   task automatic model_edge();
      if (!m_busy) begin
         if (start) begin m_busy = 1; m_k = 0; end
      end else if (m_valid) begin
         if (out_ready) begin
            m_valid = 0;
            m_k     = 0;
            m_busy  = start;
         end
      end else if (m_k + 1 == NUM_ITER) begin
         m_x = x_in; m_y = y_in; m_z = z_in;
         m_valid = 1; m_k = 0;
      end else begin
         m_k++;
      end
   endtask

   task automatic check_all();
      bit running;
      running = m_busy && !m_valid;
      chk("busy", 32'(busy), 32'(m_busy));
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("iter", 32'(iter), running ? 32'(m_k) : 32'd0);
      chk("first_iter", 32'(first_iter), 32'(running && m_k == 0));
      chk("x_out", 32'(x_out), 32'(m_x));
      chk("y_out", 32'(y_out), 32'(m_y));
      chk("z_out", 32'(z_out), 32'(m_z));
   endtask

   task automatic cycle(input bit s, input bit r);
      @(negedge clk);
      start     = s;
      out_ready = r;
      if (rnd) begin
         x_in = 16'($urandom); y_in = 16'($urandom); z_in = 16'($urandom);
      end
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      int n, fi_cnt, v_cnt;
      rst = 1'b1; start = 1'b0; out_ready = 1'b0;
      x_in = 16'h1234; y_in = 16'h0567; z_in = 16'h0ABC;
      #2;
      check_all();
      #8 rst = 1'b0;

      // Idle with no start
      for (int i = 0; i < 20; i++) cycle(0, $urandom_range(0, 1));

      // Basic conversion with fixed operands
      cycle(1, 1);
      fi_cnt = int'(first_iter);
      n = 0;
      while (!out_valid && n < 40) begin
         cycle(0, 1);
         n++;
         fi_cnt += int'(first_iter);
      end
      chk("latency", 32'(n), 32'd16);
      chk("first_iter_count", 32'(fi_cnt), 32'd1);
      chk("basic_x_out", 32'(x_out), 32'h1234);
      chk("basic_y_out", 32'(y_out), 32'h0567);
      chk("basic_z_out", 32'(z_out), 32'h0ABC);
      cycle(0, 1);
      chk("busy_after_handshake", 32'(busy), 32'd0);

      // Backpressure with changing inputs
      rnd = 1'b1;
      cycle(1, 0);
      n = 0;
      while (!out_valid && n < 40) begin cycle($urandom_range(0, 1), 0); n++; end
      chk("bp_latency", 32'(n), 32'd16);
      for (int i = 0; i < 5; i++) begin
         cycle($urandom_range(0, 1), 0);
         chk("bp_hold_x", 32'(x_out), 32'(m_x));
      end
      cycle(0, 1);
      chk("bp_handshake", 32'(out_valid), 32'd0);

      // Back-to-back conversions
      v_cnt = 0;
      for (int i = 0; i < 3 * (NUM_ITER + 1); i++) begin
         cycle(1, 1);
         v_cnt += int'(out_valid);
      end
      chk("b2b_valid_count", 32'(v_cnt), 32'd3);
      cycle(0, 1);
      for (int i = 0; i < 3; i++) cycle(0, $urandom_range(0, 1));

      // Start pulsed mid-run is ignored
      v_cnt = 0;
      cycle(1, 1);
      n = 0;
      while (iter != 4'd7 && n < 20) begin cycle(0, 1); n++; end
      chk("reach_iter7", 32'(iter), 32'd7);
      cycle(1, 1);
      for (int i = 0; i < 40; i++) begin
         cycle(0, 1);
         v_cnt += int'(out_valid);
      end
      chk("ignored_start_results", 32'(v_cnt), 32'd1);

      // Asynchronous reset at iter 9
      cycle(1, 0);
      n = 0;
      while (iter != 4'd9 && n < 20) begin cycle(0, 0); n++; end
      chk("reach_iter9", 32'(iter), 32'd9);
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all();
      @(negedge clk) rst = 1'b0;
      cycle(0, 1);
      cycle(1, 1);
      n = 0;
      while (!out_valid && n < 40) begin cycle(0, 1); n++; end
      chk("post_reset_latency", 32'(n), 32'd16);
      cycle(0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
